// File: rtl/rr_arbiter_3_pkg.sv
// Shared types and helpers for the 3-way round-robin arbiter.
// State encoding, requester count, index/one-hot helpers.
package rr_arbiter_3_pkg;

  localparam int N_REQ = 3;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  // Next index modulo 3.
  function automatic logic [1:0] inc3(
    input logic [1:0] x
  );
    return (x >= 2'd2) ? 2'd0 : x + 2'd1;
  endfunction

  // Bit of a 3-bit vector selected by a 2-bit index.
  function automatic logic bit3(
    input logic [2:0] v,
    input logic [1:0] i
  );
    logic b;
    case (i)
      2'd0:    b = v[0];
      2'd1:    b = v[1];
      default: b = v[2];
    endcase
    return b;
  endfunction

  function automatic logic [2:0] onehot3(
    input logic [1:0] i
  );
    logic [2:0] o;
    case (i)
      2'd0:    o = 3'b001;
      2'd1:    o = 3'b010;
      default: o = 3'b100;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rr_arbiter_3_pick.sv
// Rotating-priority scan: first set request after `last`.
// Ports: req[2:0], last[1:0] in; pick[1:0], any out.
module rr_arbiter_3_pick
  import rr_arbiter_3_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [1:0]       last,
  output logic [1:0]       pick,
  output logic             any
);

  logic [1:0] c0;
  logic [1:0] c1;
  logic [1:0] c2;

  // Scan order: last+1, last+2, last.
  assign c0  = inc3(last);
  assign c1  = inc3(c0);
  assign c2  = last;
  assign any = |req;

  always_comb begin
    pick = 2'd0;
    priority case (1'b1)
      bit3(req, c0): pick = c0;
      bit3(req, c1): pick = c1;
      bit3(req, c2): pick = c2;
      default:       pick = 2'd0;
    endcase
  end

endmodule

// File: rtl/rr_arbiter_3.sv
// Three-requester round-robin arbiter, done/hold-timeout release.
// Ports: clk, rst, req[2:0], done; gnt[2:0], gnt_id[1:0], busy, timeout.
module rr_arbiter_3
  import rr_arbiter_3_pkg::*;
#(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             done,
  output logic [N_REQ-1:0] gnt,
  output logic [1:0]       gnt_id,
  output logic             busy,
  output logic             timeout
);

  state_t           state;
  state_t           state_n;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] cnt_n;
  logic [1:0]       last;
  logic [1:0]       last_n;
  logic [2:0]       gnt_n;
  logic [1:0]       gid_n;
  logic             busy_n;
  logic             tmo_n;

  logic [1:0] pick;
  logic       any;
  logic       held;
  logic       cnt_max;
  logic       rel;

  rr_arbiter_3_pick u_pick (
    .req  (req),
    .last (last),
    .pick (pick),
    .any  (any)
  );

  assign held    = |(req & gnt);
  assign cnt_max = (hold_cnt == CNT_W'(MAX_HOLD - 1));
  assign rel     = done | ~held | cnt_max;

  always_comb begin
    state_n = state;
    cnt_n   = hold_cnt;
    last_n  = last;
    gnt_n   = gnt;
    gid_n   = gnt_id;
    busy_n  = busy;
    tmo_n   = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (any) begin
          state_n = ST_GRANT;
          gnt_n   = onehot3(pick);
          gid_n   = pick;
          last_n  = pick;
          cnt_n   = '0;
          busy_n  = 1'b1;
        end
      end
      ST_GRANT: begin
        if (rel) begin
          state_n = ST_IDLE;
          gnt_n   = '0;
          gid_n   = '0;
          busy_n  = 1'b0;
          // Only a pure counter expiry is a timeout.
          tmo_n   = cnt_max & ~done & held;
        end else begin
          cnt_n = hold_cnt + CNT_W'(1);
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_IDLE;
      hold_cnt <= '0;
      last     <= 2'd2;
      gnt      <= '0;
      gnt_id   <= '0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_n;
      hold_cnt <= cnt_n;
      last     <= last_n;
      gnt      <= gnt_n;
      gnt_id   <= gid_n;
      busy     <= busy_n;
      timeout  <= tmo_n;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_3.sv
// Scoreboard bench for rr_arbiter_3 (MAX_HOLD=4).
// Directed per-cycle vectors; monitor compares every cycle.
module tb_rr_arbiter_3;

  logic       clk;
  logic       rst;
  logic [2:0] req;
  logic       done;
  logic [2:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;
  logic       timeout;

  typedef struct {
    logic [2:0] g;
    logic       t;
    string      tag;
  } exp_t;

  exp_t q[$];
  int   n_cmp;
  int   n_bad;
  bit   stim_done;

  rr_arbiter_3 #(
    .MAX_HOLD (4),
    .CNT_W    (4)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_id  (gnt_id),
    .busy    (busy),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(
    input logic [2:0] g
  );
    logic [1:0] r;
    case (g)
      3'b010:  r = 2'd1;
      3'b100:  r = 2'd2;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  task automatic chk(
    input string n,
    input logic [2:0] act,
    input logic [2:0] req_v
  );
    n_cmp++;
    if (act !== req_v) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", n, act, req_v);
    end
  endtask

  // Drive one cycle; expected outputs after the coming edge.
  task automatic step(
    input logic       rs,
    input logic [2:0] r,
    input logic       d,
    input logic [2:0] eg,
    input logic       et,
    input string      tag
  );
    exp_t e;
    rst  = rs;
    req  = r;
    done = d;
    @(posedge clk);
    e.g   = eg;
    e.t   = et;
    e.tag = tag;
    q.push_back(e);
    #1;
  endtask

  // Monitor: pop and compare after every edge that has an expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk({e.tag, ".gnt"}, gnt, e.g);
        chk({e.tag, ".gnt_id"}, {1'b0, gnt_id},
            {1'b0, idx_of(e.g)});
        chk({e.tag, ".busy"}, {2'b0, busy},
            {2'b0, |e.g});
        chk({e.tag, ".timeout"}, {2'b0, timeout},
            {2'b0, e.t});
        chk({e.tag, ".onehot"},
            {2'b0, $onehot0(gnt)}, 3'b001);
      end
    end
  end

  initial begin
    n_cmp     = 0;
    n_bad     = 0;
    stim_done = 1'b0;
    rst  = 1'b1;
    req  = 3'b000;
    done = 1'b0;

    // Reset with all requesting.
    step(1, 3'b111, 0, 3'b000, 0, "rst0");
    step(1, 3'b111, 0, 3'b000, 0, "rst1");
    step(0, 3'b111, 0, 3'b001, 0, "rst_rel");

    // Rotation.
    step(0, 3'b111, 1, 3'b000, 0, "rot1");
    step(0, 3'b111, 0, 3'b010, 0, "rot2");
    step(0, 3'b111, 1, 3'b000, 0, "rot3");
    step(0, 3'b111, 0, 3'b100, 0, "rot4");
    step(0, 3'b111, 1, 3'b000, 0, "rot5");
    step(0, 3'b111, 0, 3'b001, 0, "rot6");
    step(0, 3'b111, 1, 3'b000, 0, "rot7");

    // Single requester, drop request.
    step(0, 3'b100, 0, 3'b100, 0, "sgl1");
    step(0, 3'b100, 0, 3'b100, 0, "sgl2");
    step(0, 3'b000, 0, 3'b000, 0, "sgl_drop");
    step(0, 3'b000, 0, 3'b000, 0, "sgl_idle");

    // Timeout after 4 held cycles.
    step(0, 3'b010, 0, 3'b010, 0, "to1");
    step(0, 3'b010, 0, 3'b010, 0, "to2");
    step(0, 3'b010, 0, 3'b010, 0, "to3");
    step(0, 3'b010, 0, 3'b010, 0, "to4");
    step(0, 3'b010, 0, 3'b000, 1, "to_rel");
    step(0, 3'b010, 0, 3'b010, 0, "to_regnt");

    // Done on the same cycle as the counter limit.
    step(0, 3'b010, 0, 3'b010, 0, "dt2");
    step(0, 3'b010, 0, 3'b010, 0, "dt3");
    step(0, 3'b010, 0, 3'b010, 0, "dt4");
    step(0, 3'b010, 1, 3'b000, 0, "dt_rel");
    step(0, 3'b000, 0, 3'b000, 0, "dt_idle");

    // Reset mid-grant restores priority.
    step(0, 3'b010, 0, 3'b010, 0, "mr_gnt");
    step(1, 3'b010, 0, 3'b000, 0, "mr_rst");
    step(1, 3'b111, 0, 3'b000, 0, "mr_rst2");
    step(0, 3'b111, 0, 3'b001, 0, "mr_pri");
    step(0, 3'b111, 1, 3'b000, 0, "mr_rel");

    // done in IDLE is ignored.
    step(0, 3'b000, 1, 3'b000, 0, "idle_done");
    step(0, 3'b001, 1, 3'b001, 0, "idle_done_gnt");
    step(0, 3'b001, 1, 3'b000, 0, "idle_done_rel");

    // Skip-over: last=0, req=101.
    step(0, 3'b101, 0, 3'b100, 0, "skip1");
    step(0, 3'b101, 1, 3'b000, 0, "skip1_rel");
    step(0, 3'b101, 0, 3'b001, 0, "skip2");
    step(0, 3'b101, 1, 3'b000, 0, "skip2_rel");
    step(0, 3'b000, 0, 3'b000, 0, "end");

    stim_done = 1'b1;
    for (int i = 0; i < 20 && q.size() > 0; i++)
      @(posedge clk);
    if (q.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL drain: got %0d pending expected 0",
               q.size());
    end
    @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
